regfile_access_ctrl: RTL and testbench

//  Sequencer and arbiter for the 16x8 register file behind the board's 7-segment read/write demo.

---
 rtl/regfile_access_ctrl_pkg.sv | 15 +
 rtl/regfile_access_ctrl_rr_arb2.sv | 15 +
 rtl/regfile_access_ctrl.sv | 147 ++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared types and sizes for the register-file access sequencer.
package regfile_access_ctrl_pkg;

   localparam int RF_AW = 4;
   localparam int RF_DW = 8;

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_IDLE   = 3'd1,
      ST_ACCESS = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

endpackage

// File: rtl/regfile_access_ctrl_rr_arb2.sv
// Two-way round-robin pick; on a tie the requester not served last wins.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last_gnt,
   output logic gnt_vld,
   output logic gnt_id
);

   always_comb begin
      gnt_vld = req0 | req1;
      gnt_id  = req1 & (~req0 | ~last_gnt);
   end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Fills the register file after reset, then serves two requesters
// through its single synchronous-read port, one access per four cycles.
module regfile_access_ctrl
   import regfile_access_ctrl_pkg::*;
#(
   parameter int AW      = RF_AW,
   parameter int DW      = RF_DW,
   parameter int INIT_EN = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          rw0,
   input  logic          rw1,
   input  logic [AW-1:0] adr0,
   input  logic [AW-1:0] adr1,
   input  logic [DW-1:0] wd0,
   input  logic [DW-1:0] wd1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata,
   output logic          busy,
   output logic [DW-1:0] disp_value,
   output logic [AW-1:0] rf_adr,
   output logic [DW-1:0] rf_wdata,
   output logic          rf_we,
   input  logic [DW-1:0] rf_rdata
);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          last_gnt_q, last_gnt_d;
   logic          gnt_q, gnt_d;
   logic          rw_q, rw_d;
   logic [AW-1:0] rf_adr_q, rf_adr_d;
   logic [DW-1:0] rf_wdata_q, rf_wdata_d;
   logic          rf_we_q, rf_we_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] disp_q, disp_d;
   logic          busy_q, busy_d;
   logic          arb_vld;
   logic          arb_id;

   rr_arb2 u_arb (
      .req0     (req0),
      .req1     (req1),
      .last_gnt (last_gnt_q),
      .gnt_vld  (arb_vld),
      .gnt_id   (arb_id)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_gnt_d = last_gnt_q;
      gnt_d      = gnt_q;
      rw_d       = rw_q;
      rf_adr_d   = rf_adr_q;
      rf_wdata_d = rf_wdata_q;
      rf_we_d    = 1'b0;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      rdata_d    = rdata_q;
      disp_d     = disp_q;
      unique case (state_q)
         ST_INIT: begin
            rf_we_d    = 1'b1;
            rf_adr_d   = cnt_q;
            rf_wdata_d = DW'(cnt_q);
            cnt_d      = cnt_q + AW'(1);
            if (cnt_q == {AW{1'b1}}) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (arb_vld) begin
               gnt_d      = arb_id;
               last_gnt_d = arb_id;
               rw_d       = arb_id ? rw1 : rw0;
               rf_we_d    = arb_id ? rw1 : rw0;
               rf_adr_d   = arb_id ? adr1 : adr0;
               rf_wdata_d = arb_id ? wd1 : wd0;
               state_d    = ST_ACCESS;
            end
         end
         ST_ACCESS: state_d = ST_WAIT;
         ST_WAIT: begin
            if (rw_q) begin
               disp_d = rf_wdata_q;
            end else begin
               rdata_d = rf_rdata;
               disp_d  = rf_rdata;
            end
            ack0_d  = ~gnt_q;
            ack1_d  = gnt_q;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // stays high through the cycle that commits the last fill write
      busy_d = (state_d != ST_IDLE) || (state_q == ST_INIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= (INIT_EN != 0) ? ST_INIT : ST_IDLE;
         busy_q     <= (INIT_EN != 0);
         cnt_q      <= '0;
         last_gnt_q <= 1'b1;
         gnt_q      <= 1'b0;
         rw_q       <= 1'b0;
         rf_adr_q   <= '0;
         rf_wdata_q <= '0;
         rf_we_q    <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         rdata_q    <= '0;
         disp_q     <= '0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
         last_gnt_q <= last_gnt_d;
         gnt_q      <= gnt_d;
         rw_q       <= rw_d;
         rf_adr_q   <= rf_adr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_we_q    <= rf_we_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         rdata_q    <= rdata_d;
         disp_q     <= disp_d;
      end
   end

   assign ack0       = ack0_q;
   assign ack1       = ack1_q;
   assign rdata      = rdata_q;
   assign busy       = busy_q;
   assign disp_value = disp_q;
   assign rf_adr     = rf_adr_q;
   assign rf_wdata   = rf_wdata_q;
   assign rf_we      = rf_we_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a 16x8 sync-read file model.
module tb_regfile_access_ctrl;

   logic       clk;
   logic       rst_n;
   logic       req0, req1, rw0, rw1;
   logic [3:0] adr0, adr1;
   logic [7:0] wd0, wd1;
   logic       ack0, ack1, busy, rf_we;
   logic [7:0] rdata, disp_value, rf_wdata, rf_rdata;
   logic [3:0] rf_adr;

   logic [7:0] mem [16];
   int         checks;
   int         errors;
   logic [7:0] rd;
   int         lat;

   regfile_access_ctrl #(.AW(4), .DW(8), .INIT_EN(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0       (req0),
      .req1       (req1),
      .rw0        (rw0),
      .rw1        (rw1),
      .adr0       (adr0),
      .adr1       (adr1),
      .wd0        (wd0),
      .wd1        (wd1),
      .ack0       (ack0),
      .ack1       (ack1),
      .rdata      (rdata),
      .busy       (busy),
      .disp_value (disp_value),
      .rf_adr     (rf_adr),
      .rf_wdata   (rf_wdata),
      .rf_we      (rf_we),
      .rf_rdata   (rf_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rf_we) mem[rf_adr] <= rf_wdata;
      rf_rdata <= mem[rf_adr];
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic access(input bit id, input bit w, input logic [3:0] a,
                         input logic [7:0] d, output logic [7:0] r,
                         output int l);
      @(negedge clk);
      if (id) begin
         req1 = 1'b1; rw1 = w; adr1 = a; wd1 = d;
      end else begin
         req0 = 1'b1; rw0 = w; adr0 = a; wd0 = d;
      end
      l = 0;
      r = 8'h00;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 1) begin
            adr0 = ~a; wd0 = ~d;
            adr1 = ~a; wd1 = ~d;
         end
         if (ack0 || ack1) begin
            l = i;
            break;
         end
      end
      chk("ack_seen", (l != 0), 1);
      chk("ack_who", {ack1, ack0}, id ? 2'b10 : 2'b01);
      r = rdata;
      req0 = 1'b0;
      req1 = 1'b0;
   endtask

   int         n_ack;
   int         ovl;
   int         first_ack;
   int         stray;
   logic       ack_id [4];
   int         ack_cyc [4];
   logic [7:0] ack_dat [4];

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
      rf_rdata = 8'h00;
      rst_n = 1'b0;
      req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
      adr0 = 0; adr1 = 0; wd0 = 0; wd1 = 0;

      // reset values and fill sequence
      repeat (2) @(negedge clk);
      chk("rst_ack", {ack1, ack0}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_disp", disp_value, 0);
      chk("rst_rfadr", rf_adr, 0);
      chk("rst_rfwd", rf_wdata, 0);
      chk("rst_rfwe", rf_we, 0);
      chk("rst_busy", busy, 1);
      rst_n = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk("init_we", rf_we, 1);
         chk("init_adr", rf_adr, i);
         chk("init_wd", rf_wdata, i);
         chk("init_busy", busy, 1);
      end
      @(negedge clk);
      chk("init_busy_c17", busy, 0);
      chk("init_we_c17", rf_we, 0);
      access(1'b1, 1'b0, 4'd9, 8'h00, rd, lat);
      chk("rd9", rd, 8'h09);
      chk("disp9", disp_value, 8'h09);

      // write then read back through requester 0
      access(1'b0, 1'b1, 4'd3, 8'hC8, rd, lat);
      chk("wr3_lat", lat, 3);
      chk("wr3_disp", disp_value, 8'hC8);
      chk("wr3_rdata_hold", rdata, 8'h09);
      access(1'b0, 1'b0, 4'd3, 8'h00, rd, lat);
      chk("rd3_lat", lat, 3);
      chk("rd3", rd, 8'hC8);
      chk("rd3_disp", disp_value, 8'hC8);

      // top address, and address 0 untouched
      access(1'b1, 1'b1, 4'd15, 8'hFF, rd, lat);
      access(1'b1, 1'b0, 4'd15, 8'h00, rd, lat);
      chk("rd15", rd, 8'hFF);
      access(1'b1, 1'b0, 4'd0, 8'h00, rd, lat);
      chk("rd0", rd, 8'h00);

      // continuous contention, last served was requester 1
      @(negedge clk);
      req0 = 1; rw0 = 0; adr0 = 4'd2;
      req1 = 1; rw1 = 0; adr1 = 4'd11;
      n_ack = 0;
      ovl = 0;
      for (int n = 1; n <= 30; n++) begin
         @(negedge clk);
         if (ack0 && ack1) ovl++;
         if ((ack0 || ack1) && n_ack < 4) begin
            ack_id[n_ack] = ack1;
            ack_cyc[n_ack] = n;
            ack_dat[n_ack] = rdata;
            n_ack++;
            if (n_ack == 4) begin
               req0 = 0;
               req1 = 0;
            end
         end
      end
      req0 = 0;
      req1 = 0;
      chk("rr_count", n_ack, 4);
      chk("rr_overlap", ovl, 0);
      for (int k = 0; k < n_ack; k++) begin
         chk("rr_id", ack_id[k], k % 2);
         chk("rr_dat", ack_dat[k], (k % 2) ? 8'h0B : 8'h02);
         chk("rr_cyc", ack_cyc[k], 3 + 4 * k);
      end

      // request during fill is held off until the first idle edge
      @(negedge clk);
      rst_n = 1'b0;
      req1 = 1; rw1 = 0; adr1 = 4'd6;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first_ack = 0;
      stray = 0;
      for (int c = 1; c <= 24; c++) begin
         @(negedge clk);
         if (ack0) stray++;
         if (ack1 && first_ack == 0) begin
            first_ack = c;
            rd = rdata;
            req1 = 0;
         end
      end
      req1 = 0;
      chk("init_req_ack_cyc", first_ack, 19);
      chk("init_req_rd", rd, 8'h06);
      chk("init_req_stray", stray, 0);

      // reset lands during a write access
      @(negedge clk);
      req0 = 1; rw0 = 1; adr0 = 4'd5; wd0 = 8'h55;
      @(negedge clk);
      chk("abort_we", rf_we, 1);
      chk("abort_adr", rf_adr, 5);
      chk("abort_wd", rf_wdata, 8'h55);
      rst_n = 1'b0;
      req0 = 0;
      #1;
      chk("abort_rfwe", rf_we, 0);
      chk("abort_rfadr", rf_adr, 0);
      chk("abort_rfwd", rf_wdata, 0);
      chk("abort_rdata", rdata, 0);
      chk("abort_disp", disp_value, 0);
      chk("abort_busy", busy, 1);
      stray = 0;
      repeat (3) begin
         @(negedge clk);
         if (ack0 || ack1) stray++;
      end
      chk("abort_noack", stray, 0);
      chk("abort_mem5", mem[5], 8'h05);
      rst_n = 1'b1;
      repeat (17) begin
         @(negedge clk);
         if (ack0 || ack1) stray++;
      end
      chk("abort_noack2", stray, 0);
      chk("abort_busy_c17", busy, 0);
      access(1'b0, 1'b0, 4'd5, 8'h00, rd, lat);
      chk("abort_rd5", rd, 8'h05);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
